// File: rtl/serial_cla_adder_64.sv
// serial_cla_adder_64: multi-cycle WIDTH-bit add/subtract built on one 8-bit
// carry look-ahead slice adder, walked LSB slice first with a registered carry.
// Optional build macro: SERIAL_CLA_ZERO_FLAG_EN adds a 'zero' result flag.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; last result/flags held
// RUN   | one 8-bit slice per cycle, carry chained through carry_q
// DONE  | final slice written; done pulses on the following cycle

module carry_look_ahead_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // generate/propagate terms and look-ahead carries
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum   = p ^ c[7:0];
        c_out = c[8];
    end
endmodule

module serial_cla_adder_64 #(
    parameter int WIDTH = 64   // must be a multiple of 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
`ifdef SERIAL_CLA_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    localparam int NSLICE = WIDTH / 8;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;      // already inverted for subtract
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [7:0]        slice_a;
    logic [7:0]        slice_b;
    logic [7:0]        slice_sum;
    logic              slice_cout;
    logic              last_slice;
    logic              accept;

    assign slice_a    = a_q[idx_q*8 +: 8];
    assign slice_b    = b_q[idx_q*8 +: 8];
    assign last_slice = (idx_q == IDXW'(NSLICE - 1));
    assign accept     = (state_q == IDLE) && start;
    assign busy       = (state_q == RUN);

    carry_look_ahead_adder_8 u_slice_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_CLA_ZERO_FLAG_EN
    logic zero_acc_q;   // running AND of "slice sum was zero"

    // zero flag: accumulated per slice, published on the final slice
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_acc_q <= 1'b0;
            zero       <= 1'b0;
        end else if (accept) begin
            zero_acc_q <= 1'b1;
        end else if (state_q == RUN) begin
            zero_acc_q <= zero_acc_q & (slice_sum == 8'd0);
            if (last_slice) begin
                zero <= zero_acc_q & (slice_sum == 8'd0);
            end
        end
    end
`endif

    // operand capture, slice write-back, flags and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done trails the DONE state by one edge so it lands after the final write settles
            done <= (state_q == DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= sub;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                result[idx_q*8 +: 8] <= slice_sum;
                carry_q              <= slice_cout;
                idx_q                <= idx_q + 1'b1;
                if (last_slice) begin
                    carry_out <= slice_cout;
                    overflow  <= (slice_a[7] == slice_b[7]) && (slice_sum[7] != slice_a[7]);
                end
            end
        end
    end
endmodule
